// File: rtl/binary_search_ctrl_pkg.sv
// Shared types and default sizing for the binary search controller.
package binary_search_ctrl_pkg;

    // Controller states; done/err are output pulses, not states.
    typedef enum logic {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } state_e;

    localparam int DEF_W    = 4;
    localparam int DEF_MAXP = DEF_W + 1;

endpackage

// File: rtl/binary_search_ctrl.sv
// Binary search controller: drives a registered probe value into an external
// comparator and narrows [lo, hi] from the equal/greater/lower flags until the
// target is found (done) or the search becomes impossible (err).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; probe/result/steps hold their last value
// PROBE | probe is on the comparator; flags are consumed every cycle
module binary_search_ctrl
    import binary_search_ctrl_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int MAXP = W + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        equal,
    input  logic                        greater,
    input  logic                        lower,
    output logic [W-1:0]                probe,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [W-1:0]                result,
    output logic [$clog2(MAXP+1)-1:0]   steps
);

    localparam int SW = $clog2(MAXP + 1);
    localparam logic [SW-1:0] MAXP_L = SW'(MAXP);

    state_e         state_q, state_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   probe_q, probe_d;
    logic [W-1:0]   result_q, result_d;
    logic [SW-1:0]  steps_q, steps_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic [SW-1:0]  step_inc;
    logic [W:0]     probe_up;
    logic [W:0]     lo_plus1;
    logic           range_cross_up;
    logic           range_cross_dn;
    logic           out_of_probes;

    // Midpoint computed one bit wider so lo+hi never wraps.
    function automatic logic [W-1:0] midpoint(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return W'(s >> 1);
    endfunction

    // Range guards: greater needs probe+1 <= hi, lower needs probe-1 >= lo.
    always_comb begin
        step_inc       = steps_q + 1'b1;
        probe_up       = {1'b0, probe_q} + 1'b1;
        lo_plus1       = {1'b0, lo_q} + 1'b1;
        range_cross_up = probe_up > {1'b0, hi_q};
        range_cross_dn = {1'b0, probe_q} < lo_plus1;
        out_of_probes  = step_inc >= MAXP_L;
    end

    // Next-state and datapath update; pulses default low every cycle.
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        probe_d  = probe_q;
        result_d = result_q;
        steps_d  = steps_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A pending done/err pulse means the previous search is still
                // retiring; start is not honoured until the following cycle.
                if (start && !done_q && !err_q) begin
                    lo_d    = '0;
                    hi_d    = '1;
                    steps_d = '0;
                    probe_d = midpoint('0, '1);
                    state_d = PROBE;
                end
            end
            PROBE: begin
                unique case ({equal, greater, lower})
                    3'b100: begin
                        result_d = probe_q;
                        steps_d  = step_inc;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end
                    3'b010: begin
                        if (range_cross_up || out_of_probes) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            lo_d    = W'(probe_up);
                            probe_d = midpoint(W'(probe_up), hi_q);
                            steps_d = step_inc;
                        end
                    end
                    3'b001: begin
                        if (range_cross_dn || out_of_probes) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            hi_d    = probe_q - 1'b1;
                            probe_d = midpoint(lo_q, probe_q - 1'b1);
                            steps_d = step_inc;
                        end
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            probe_q  <= '0;
            result_q <= '0;
            steps_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            probe_q  <= probe_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign probe  = probe_q;
    assign busy   = (state_q == PROBE);
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
    assign steps  = steps_q;

endmodule

// File: tb/tb_binary_search_ctrl.sv
// Directed testbench for binary_search_ctrl with a behavioural comparator.
module tb_binary_search_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       equal, greater, lower;
    logic [3:0] probe;
    logic       busy, done, err;
    logic [3:0] result;
    logic [2:0] steps;

    logic [3:0] target;
    int         flag_mode;      // 0 honest comparator, 1 equal+greater, 2 always greater

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] plog [0:7];
    int         nprobe;
    int         lat;
    logic       saw_err, saw_done, saw_both;

    binary_search_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .equal   (equal),
        .greater (greater),
        .lower   (lower),
        .probe   (probe),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result),
        .steps   (steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign equal   = ((flag_mode == 0) && (target == probe)) || (flag_mode == 1);
    assign greater = ((flag_mode == 0) && (target > probe)) || (flag_mode == 1) || (flag_mode == 2);
    assign lower   = (flag_mode == 0) && (target < probe);

    // Pulse start for one cycle, then log probes until done/err or timeout.
    task automatic run_search(input logic [3:0] tgt);
        target   = tgt;
        nprobe   = 0;
        saw_err  = 1'b0;
        saw_done = 1'b0;
        saw_both = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && !err && lat < 20) begin
            if (busy && nprobe < 8) plog[nprobe] = probe;
            if (busy) nprobe++;
            @(negedge clk);
            lat++;
        end
        saw_done = done;
        saw_err  = err;
        saw_both = done && err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; target = '0; flag_mode = 0;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (probe !== 4'd0)  begin n_bad++; $display("FAIL rst_probe got %0d want 0", probe); end
        n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)   begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
        n_cmp++; if (err !== 1'b0)    begin n_bad++; $display("FAIL rst_err got %b want 0", err); end
        n_cmp++; if (result !== 4'd0) begin n_bad++; $display("FAIL rst_result got %0d want 0", result); end
        n_cmp++; if (steps !== 3'd0)  begin n_bad++; $display("FAIL rst_steps got %0d want 0", steps); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        run_search(4'd7);
        n_cmp++; if (saw_done !== 1'b1) begin n_bad++; $display("FAIL single_done got %b want 1", saw_done); end
        n_cmp++; if (lat != 2)          begin n_bad++; $display("FAIL single_latency got %0d want 2", lat); end
        n_cmp++; if (nprobe != 1)       begin n_bad++; $display("FAIL single_nprobe got %0d want 1", nprobe); end
        n_cmp++; if (plog[0] !== 4'd7)  begin n_bad++; $display("FAIL single_probe got %0d want 7", plog[0]); end
        n_cmp++; if (result !== 4'd7)   begin n_bad++; $display("FAIL single_result got %0d want 7", result); end
        n_cmp++; if (steps !== 3'd1)    begin n_bad++; $display("FAIL single_steps got %0d want 1", steps); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL single_busy_at_done got %b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL single_done_pulse got %b want 0", done); end
        n_cmp++; if (probe !== 4'd7)    begin n_bad++; $display("FAIL single_probe_hold got %0d want 7", probe); end
    endtask

    task automatic test_min();
        logic [3:0] exp_p [0:3];
        exp_p[0] = 4'd7; exp_p[1] = 4'd3; exp_p[2] = 4'd1; exp_p[3] = 4'd0;
        run_search(4'd0);
        n_cmp++; if (nprobe != 4) begin n_bad++; $display("FAIL min_nprobe got %0d want 4", nprobe); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (plog[i] !== exp_p[i]) begin n_bad++; $display("FAIL min_probe[%0d] got %0d want %0d", i, plog[i], exp_p[i]); end
        end
        n_cmp++; if (lat != 5)         begin n_bad++; $display("FAIL min_latency got %0d want 5", lat); end
        n_cmp++; if (saw_err !== 1'b0) begin n_bad++; $display("FAIL min_err got %b want 0", saw_err); end
        n_cmp++; if (result !== 4'd0)  begin n_bad++; $display("FAIL min_result got %0d want 0", result); end
        n_cmp++; if (steps !== 3'd4)   begin n_bad++; $display("FAIL min_steps got %0d want 4", steps); end
        @(negedge clk);
    endtask

    task automatic test_max();
        logic [3:0] exp_p [0:4];
        exp_p[0] = 4'd7; exp_p[1] = 4'd11; exp_p[2] = 4'd13; exp_p[3] = 4'd14; exp_p[4] = 4'd15;
        run_search(4'd15);
        n_cmp++; if (nprobe != 5) begin n_bad++; $display("FAIL max_nprobe got %0d want 5", nprobe); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (plog[i] !== exp_p[i]) begin n_bad++; $display("FAIL max_probe[%0d] got %0d want %0d", i, plog[i], exp_p[i]); end
        end
        n_cmp++; if (lat != 6)          begin n_bad++; $display("FAIL max_latency got %0d want 6", lat); end
        n_cmp++; if (saw_both !== 1'b0) begin n_bad++; $display("FAIL max_done_and_err got %b want 0", saw_both); end
        n_cmp++; if (result !== 4'd15)  begin n_bad++; $display("FAIL max_result got %0d want 15", result); end
        n_cmp++; if (steps !== 3'd5)    begin n_bad++; $display("FAIL max_steps got %0d want 5", steps); end
        @(negedge clk);
    endtask

    task automatic test_bad_flags();
        flag_mode = 1;
        run_search(4'd3);
        flag_mode = 0;
        n_cmp++; if (lat != 2)          begin n_bad++; $display("FAIL badflag_latency got %0d want 2", lat); end
        n_cmp++; if (saw_err !== 1'b1)  begin n_bad++; $display("FAIL badflag_err got %b want 1", saw_err); end
        n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL badflag_done got %b want 0", saw_done); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL badflag_busy got %b want 0", busy); end
        n_cmp++; if (result !== 4'd15)  begin n_bad++; $display("FAIL badflag_result got %0d want 15", result); end
        n_cmp++; if (steps !== 3'd0)    begin n_bad++; $display("FAIL badflag_steps got %0d want 0", steps); end
        @(negedge clk);
        n_cmp++; if (err !== 1'b0)      begin n_bad++; $display("FAIL badflag_err_pulse got %b want 0", err); end
    endtask

    task automatic test_overflow();
        flag_mode = 2;
        run_search(4'd0);
        flag_mode = 0;
        n_cmp++; if (nprobe != 5)       begin n_bad++; $display("FAIL ovf_nprobe got %0d want 5", nprobe); end
        n_cmp++; if (lat != 6)          begin n_bad++; $display("FAIL ovf_latency got %0d want 6", lat); end
        n_cmp++; if (saw_err !== 1'b1)  begin n_bad++; $display("FAIL ovf_err got %b want 1", saw_err); end
        n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL ovf_done got %b want 0", saw_done); end
        n_cmp++; if (probe !== 4'd15)   begin n_bad++; $display("FAIL ovf_probe_nowrap got %0d want 15", probe); end
        n_cmp++; if (result !== 4'd15)  begin n_bad++; $display("FAIL ovf_result got %0d want 15", result); end
        n_cmp++; if (steps !== 3'd4)    begin n_bad++; $display("FAIL ovf_steps got %0d want 4", steps); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_p [0:2];
        exp_p[0] = 4'd7; exp_p[1] = 4'd11; exp_p[2] = 4'd9;
        target = 4'd15;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (probe !== 4'd13) begin n_bad++; $display("FAIL rmid_third_probe got %0d want 13", probe); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (probe !== 4'd0)  begin n_bad++; $display("FAIL rmid_probe got %0d want 0", probe); end
        n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_cmp++; if (result !== 4'd0) begin n_bad++; $display("FAIL rmid_result got %0d want 0", result); end
        n_cmp++; if (steps !== 3'd0)  begin n_bad++; $display("FAIL rmid_steps got %0d want 0", steps); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rmid_no_pulse got done=%b err=%b want 0 0", done, err); end
        run_search(4'd9);
        n_cmp++; if (nprobe != 3) begin n_bad++; $display("FAIL rmid_nprobe got %0d want 3", nprobe); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (plog[i] !== exp_p[i]) begin n_bad++; $display("FAIL rmid_probe[%0d] got %0d want %0d", i, plog[i], exp_p[i]); end
        end
        n_cmp++; if (result !== 4'd9) begin n_bad++; $display("FAIL rmid_result9 got %0d want 9", result); end
        n_cmp++; if (steps !== 3'd3)  begin n_bad++; $display("FAIL rmid_steps3 got %0d want 3", steps); end
        @(negedge clk);
    endtask

    task automatic test_start_held();
        int guard;
        target = 4'd11;
        start  = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || probe !== 4'd7)  begin n_bad++; $display("FAIL held_c1 got busy=%b probe=%0d want 1 7", busy, probe); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || probe !== 4'd11) begin n_bad++; $display("FAIL held_c2 got busy=%b probe=%0d want 1 11", busy, probe); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0)   begin n_bad++; $display("FAIL held_c3 got done=%b busy=%b want 1 0", done, busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || probe !== 4'd11) begin n_bad++; $display("FAIL held_c4 got busy=%b probe=%0d want 0 11", busy, probe); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || probe !== 4'd7)  begin n_bad++; $display("FAIL held_c5 got busy=%b probe=%0d want 1 7", busy, probe); end
        start = 1'b0;
        guard = 0;
        while (!done && !err && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++; if (done !== 1'b1)    begin n_bad++; $display("FAIL held_second_done got %b want 1", done); end
        n_cmp++; if (result !== 4'd11) begin n_bad++; $display("FAIL held_result got %0d want 11", result); end
        n_cmp++; if (steps !== 3'd2)   begin n_bad++; $display("FAIL held_steps got %0d want 2", steps); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_min();
        test_max();
        test_bad_flags();
        test_overflow();
        test_reset_mid();
        test_start_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
